// File: rtl/forward_maccum_folded_if.sv
// Handshake/bus bundle for forward_maccum_folded.
// slave  : the MAC stage itself (consumes state/weights, produces accumulators).
// master : the surrounding environment driving the stage.
interface forward_maccum_folded_if #(
    parameter int NP = 8,
    parameter int NC = 7,
    parameter int WV = 5
);
    localparam int WA = $clog2(NP) + 1 + WV;

    logic                       iMode;

    logic                       iValid_AM_WeightBias;
    logic                       oReady_AM_WeightBias;
    logic [NC*NP*WV+NC*WV-1:0]  iData_AM_WeightBias;

    logic                       iValid_AM_State0;
    logic                       oReady_AM_State0;
    logic [NP*WV-1:0]           iData_AM_State0;

    logic                       oValid_BM_Accum0;
    logic                       iReady_BM_Accum0;
    logic [NC*WA-1:0]           oData_BM_Accum0;

    logic                       oValid_BM_Accum1;
    logic                       iReady_BM_Accum1;
    logic [NC*WA-1:0]           oData_BM_Accum1;

    modport slave (
        input  iMode,
        input  iValid_AM_WeightBias, iData_AM_WeightBias,
        output oReady_AM_WeightBias,
        input  iValid_AM_State0, iData_AM_State0,
        output oReady_AM_State0,
        output oValid_BM_Accum0, oData_BM_Accum0,
        input  iReady_BM_Accum0,
        output oValid_BM_Accum1, oData_BM_Accum1,
        input  iReady_BM_Accum1
    );

    modport master (
        output iMode,
        output iValid_AM_WeightBias, iData_AM_WeightBias,
        input  oReady_AM_WeightBias,
        output iValid_AM_State0, iData_AM_State0,
        input  oReady_AM_State0,
        input  oValid_BM_Accum0, oData_BM_Accum0,
        output iReady_BM_Accum0,
        input  oValid_BM_Accum1, oData_BM_Accum1,
        output iReady_BM_Accum1
    );
endinterface

// File: rtl/forward_maccum_folded.sv
// Folded forward multiply-accumulate stage of a layer.
// Joins one state vector with one weight/bias bundle, then walks the NP inputs
// serially with NL parallel MAC lanes, one group of NL neurons at a time.
// The result is offered to the neuron stage (Accum0) and, in training mode,
// also to the delta stage (Accum1).
// Optional build macro FMF_SATURATE_EN: saturate each scaled product to WV
// bits instead of wrapping it.
module forward_maccum_folded #(
    parameter int NP = 8,
    parameter int NC = 7,
    parameter int NL = 1,
    parameter int WV = 5,
    parameter int WF = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    forward_maccum_folded_if.slave bus
);
    localparam int WA = $clog2(NP) + 1 + WV;
    localparam int NG = NC / NL;
    localparam int PW = $clog2(NP);
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
    localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

    generate
        if (NC % NL != 0) begin : gLaneCheck
            $error("forward_maccum_folded: NC must be a multiple of NL");
        end
    endgenerate

`ifdef FMF_SATURATE_EN
    localparam logic signed [2*WV-1:0] PMAX = {{(WV+1){1'b0}}, {(WV-1){1'b1}}};
    localparam logic signed [2*WV-1:0] PMIN = {{(WV+1){1'b1}}, {(WV-1){1'b0}}};
`endif

    // Scale a full-precision product back to the value format and fit it into WV bits.
    function automatic logic signed [WV-1:0] limitProd(input logic signed [2*WV-1:0] full);
        logic signed [2*WV-1:0] shifted;
        shifted = full >>> WF;
`ifdef FMF_SATURATE_EN
        if (shifted > PMAX) begin
            limitProd = PMAX[WV-1:0];
        end else if (shifted < PMIN) begin
            limitProd = PMIN[WV-1:0];
        end else begin
            limitProd = shifted[WV-1:0];
        end
`else
        limitProd = shifted[WV-1:0];
`endif
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t               state_r, stateNext_s;
    logic signed [WV-1:0] stateVal_r [NP];
    logic signed [WV-1:0] weight_r   [NG][NL][NP];
    logic signed [WA-1:0] acc_r      [NG][NL];
    logic signed [WA-1:0] accNext_s  [NG][NL];
    logic [NC*WA-1:0]     data_r;
    logic [PW-1:0]        p_r;
    logic [GW-1:0]        g_r;
    logic                 mode_r, valid0_r, valid1_r;
    logic                 accept_s, lastStep_s, take0_s, take1_s;
    logic                 readyState_s, readyWB_s;

    assign accept_s   = (state_r == IDLE) & bus.iValid_AM_State0 & bus.iValid_AM_WeightBias & ~iRST;
    assign lastStep_s = (state_r == RUN) & (p_r == P_LAST) & (g_r == G_LAST);
    assign take0_s    = valid0_r & bus.iReady_BM_Accum0;
    assign take1_s    = valid1_r & bus.iReady_BM_Accum1;

    assign bus.oReady_AM_State0     = readyState_s;
    assign bus.oReady_AM_WeightBias = readyWB_s;
    assign bus.oValid_BM_Accum0     = valid0_r;
    assign bus.oValid_BM_Accum1     = valid1_r;
    assign bus.oData_BM_Accum0      = data_r;
    assign bus.oData_BM_Accum1      = data_r;

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic and the join readies (each input waits for the other).
    always_comb begin
        stateNext_s  = state_r;
        readyState_s = 1'b0;
        readyWB_s    = 1'b0;
        case (state_r)
            IDLE: begin
                readyState_s = bus.iValid_AM_WeightBias & ~iRST;
                readyWB_s    = bus.iValid_AM_State0 & ~iRST;
                if (accept_s) begin
                    stateNext_s = RUN;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN: begin
                if (lastStep_s) begin
                    stateNext_s = OUT;
                end else begin
                    stateNext_s = RUN;
                end
            end
            OUT: begin
                if (!(valid0_r & ~take0_s) && !(valid1_r & ~take1_s)) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = OUT;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // One MAC step: every lane of the current group adds its product for input p.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            for (int l = 0; l < NL; l++) begin
                accNext_s[g][l] = acc_r[g][l];
            end
        end
        for (int l = 0; l < NL; l++) begin
            accNext_s[g_r][l] = acc_r[g_r][l] + WA'(limitProd(
                (2*WV)'(stateVal_r[p_r]) * (2*WV)'(weight_r[g_r][l][p_r])));
        end
    end

    // Operand latch, accumulators, input/group counters and output branch valids.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int p = 0; p < NP; p++) begin
                stateVal_r[p] <= '0;
            end
            for (int g = 0; g < NG; g++) begin
                for (int l = 0; l < NL; l++) begin
                    acc_r[g][l] <= '0;
                    for (int p = 0; p < NP; p++) begin
                        weight_r[g][l][p] <= '0;
                    end
                end
            end
            data_r   <= '0;
            p_r      <= '0;
            g_r      <= '0;
            mode_r   <= 1'b0;
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
        end else begin
            if (accept_s) begin
                for (int p = 0; p < NP; p++) begin
                    stateVal_r[p] <= bus.iData_AM_State0[p*WV +: WV];
                end
                for (int g = 0; g < NG; g++) begin
                    for (int l = 0; l < NL; l++) begin
                        acc_r[g][l] <= WA'($signed(bus.iData_AM_WeightBias[NC*NP*WV + (g*NL+l)*WV +: WV]));
                        for (int p = 0; p < NP; p++) begin
                            weight_r[g][l][p] <= bus.iData_AM_WeightBias[((g*NL+l)*NP+p)*WV +: WV];
                        end
                    end
                end
                mode_r <= bus.iMode;
                p_r    <= '0;
                g_r    <= '0;
            end else if (state_r == RUN) begin
                acc_r <= accNext_s;
                if (p_r == P_LAST) begin
                    p_r <= '0;
                    g_r <= (g_r == G_LAST) ? '0 : g_r + GW'(1);
                end else begin
                    p_r <= p_r + PW'(1);
                end
            end
            if (lastStep_s) begin
                for (int g = 0; g < NG; g++) begin
                    for (int l = 0; l < NL; l++) begin
                        data_r[(g*NL+l)*WA +: WA] <= accNext_s[g][l];
                    end
                end
                valid0_r <= 1'b1;
                valid1_r <= mode_r;
            end else begin
                if (take0_s) begin
                    valid0_r <= 1'b0;
                end
                if (take1_s) begin
                    valid1_r <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_forward_maccum_folded.sv
// Self-checking bench for forward_maccum_folded (NP=3, NC=4, NL=2, WV=8, WF=4).
// Hand vectors with constant expectations, join / back-pressure / reset
// sequences, and randomized transactions checked against a plain-arithmetic model.
module tb_forward_maccum_folded;
    localparam int NP     = 3;
    localparam int NC     = 4;
    localparam int NL     = 2;
    localparam int WV     = 8;
    localparam int WF     = 4;
    localparam int WA     = $clog2(NP) + 1 + WV;
    localparam int NG     = NC / NL;
    localparam int RUNLEN = NP * NG;
    localparam int SW     = NP * WV;
    localparam int WBW    = NC * NP * WV + NC * WV;
    localparam int DW     = NC * WA;

    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    forward_maccum_folded_if #(.NP(NP), .NC(NC), .WV(WV)) bus ();

    forward_maccum_folded #(.NP(NP), .NC(NC), .NL(NL), .WV(WV), .WF(WF)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [SW-1:0]  st;
        logic [WBW-1:0] wb;
        logic           mode;
        logic [DW-1:0]  exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint accField(input logic [DW-1:0] v, input int c);
        logic signed [WA-1:0] f;
        f = v[c*WA +: WA];
        return longint'(f);
    endfunction

    function automatic logic [SW-1:0] randSt();
        logic [SW-1:0] r;
        for (int i = 0; i < SW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [WBW-1:0] randWB();
        logic [WBW-1:0] r;
        for (int i = 0; i < WBW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Reference: acc[c] = bias[c] + sum_p fit((s[p]*w[c][p]) >>> WF)
    function automatic logic [DW-1:0] model(input logic [SW-1:0] st, input logic [WBW-1:0] wb);
        logic [DW-1:0] r;
        logic signed [WV-1:0] sv, wv, bv;
        longint acc, prod, m;
        for (int c = 0; c < NC; c++) begin
            bv  = wb[NC*NP*WV + c*WV +: WV];
            acc = longint'(bv);
            for (int p = 0; p < NP; p++) begin
                sv   = st[p*WV +: WV];
                wv   = wb[(c*NP+p)*WV +: WV];
                prod = (longint'(sv) * longint'(wv)) >>> WF;
`ifdef FMF_SATURATE_EN
                if (prod > 127) prod = 127;
                if (prod < -128) prod = -128;
                m = prod;
`else
                m = prod % 256;
                if (m < 0) m = m + 256;
                if (m >= 128) m = m - 256;
`endif
                acc = acc + m;
            end
            r[c*WA +: WA] = WA'(acc);
        end
        return r;
    endfunction

    task automatic setSt(input int i, input int a0, input int a1, input int a2);
        vecs[i].st = {WV'(a2), WV'(a1), WV'(a0)};
    endtask

    task automatic setN(input int i, input int c, input int w0, input int w1, input int w2, input int b);
        vecs[i].wb[c*NP*WV +: NP*WV]    = {WV'(w2), WV'(w1), WV'(w0)};
        vecs[i].wb[NC*NP*WV + c*WV +: WV] = WV'(b);
    endtask

    task automatic setExp(input int i, input int e0, input int e1, input int e2, input int e3);
        vecs[i].exp = {WA'(e3), WA'(e2), WA'(e1), WA'(e0)};
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic runTxn(input string tag, input logic [SW-1:0] st, input logic [WBW-1:0] wb,
                          input logic mode, input logic [DW-1:0] exp, input bit randReady);
        int n;
        bit bad, pend0, pend1, r0, r1;
        bus.iData_AM_State0      = st;
        bus.iData_AM_WeightBias  = wb;
        bus.iMode                = mode;
        bus.iValid_AM_State0     = 1'b1;
        bus.iValid_AM_WeightBias = 1'b1;
        bus.iReady_BM_Accum0     = 1'b0;
        bus.iReady_BM_Accum1     = 1'b0;
        #1;
        check($sformatf("%s_accept_ready", tag), {bus.oReady_AM_State0, bus.oReady_AM_WeightBias}, 2'b11);
        tick();
        n = 0;
        bad = 1'b0;
        while (!bus.oValid_BM_Accum0 && n < 200) begin
            if (bus.oReady_AM_State0 || bus.oReady_AM_WeightBias || bus.oValid_BM_Accum1) bad = 1'b1;
            bus.iMode               = ~mode;
            bus.iData_AM_State0     = randSt();
            bus.iData_AM_WeightBias = randWB();
            tick();
            n++;
        end
        check($sformatf("%s_latency", tag), n, RUNLEN);
        check($sformatf("%s_run_quiet", tag), bad, 0);
        bus.iValid_AM_State0     = 1'b0;
        bus.iValid_AM_WeightBias = 1'b0;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_acc0_%0d", tag, c), accField(bus.oData_BM_Accum0, c), accField(exp, c));
            check($sformatf("%s_acc1_%0d", tag, c), accField(bus.oData_BM_Accum1, c), accField(exp, c));
        end
        pend0 = 1'b1;
        pend1 = mode;
        bad   = 1'b0;
        n     = 0;
        while ((pend0 || pend1) && n < 200) begin
            r0 = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            r1 = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.iReady_BM_Accum0 = r0;
            bus.iReady_BM_Accum1 = r1;
            #1;
            if (bus.oValid_BM_Accum0 !== pend0 || bus.oValid_BM_Accum1 !== pend1 ||
                bus.oData_BM_Accum0 !== exp || bus.oData_BM_Accum1 !== exp ||
                bus.oReady_AM_State0 || bus.oReady_AM_WeightBias) bad = 1'b1;
            if (r0) pend0 = 1'b0;
            if (r1) pend1 = 1'b0;
            tick();
            n++;
        end
        check($sformatf("%s_out_proto", tag), bad, 0);
        check($sformatf("%s_out_done", tag), pend0 | pend1, 0);
        bus.iReady_BM_Accum0 = 1'b0;
        bus.iReady_BM_Accum1 = 1'b0;
        #1;
        check($sformatf("%s_valids_clear", tag), {bus.oValid_BM_Accum0, bus.oValid_BM_Accum1}, 2'b00);
        check($sformatf("%s_data_held", tag), accField(bus.oData_BM_Accum0, 0), accField(exp, 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        logic [SW-1:0]  rst_st;
        logic [WBW-1:0] rst_wb;
        logic           rmode;

        // Hand vectors: {state, weights/bias, mode, expected}
        for (int i = 0; i < 4; i++) vecs[i] = '0;
        setSt(0, 16, 32, 48);
        setN(0, 0, 16, 16, 0, 8);
        setN(0, 1, -16, 0, 0, 0);
        setN(0, 2, 0, 0, 16, -3);
        setN(0, 3, -16, -16, -16, 5);
        vecs[0].mode = 1'b1;
        setExp(0, 56, -16, 45, -91);

        setSt(1, 127, 0, 0);
        setN(1, 0, 127, 0, 0, 0);
        vecs[1].mode = 1'b1;
`ifdef FMF_SATURATE_EN
        setExp(1, 127, 0, 0, 0);
`else
        setExp(1, -16, 0, 0, 0);
`endif

        setSt(2, -8, 1, 16);
        setN(2, 0, 8, 16, -1, 0);
        setN(2, 1, -1, 0, 0, 0);
        setN(2, 2, 1, 0, 0, 0);
        setN(2, 3, 0, 0, 0, -100);
        vecs[2].mode = 1'b0;
        setExp(2, -4, 0, -1, -100);

        setSt(3, -128, 0, 0);
        setN(3, 0, 127, 0, 0, 0);
        setN(3, 1, -128, 0, 0, 3);
        vecs[3].mode = 1'b1;
`ifdef FMF_SATURATE_EN
        setExp(3, -128, 130, 0, 0);
`else
        setExp(3, 8, 3, 0, 0);
`endif

        // Reset with both input valids high: readies must stay low.
        iRST                     = 1'b1;
        bus.iMode                = 1'b0;
        bus.iValid_AM_State0     = 1'b1;
        bus.iValid_AM_WeightBias = 1'b1;
        bus.iData_AM_State0      = '0;
        bus.iData_AM_WeightBias  = '0;
        bus.iReady_BM_Accum0     = 1'b0;
        bus.iReady_BM_Accum1     = 1'b0;
        repeat (3) tick();
        check("reset_readies", {bus.oReady_AM_State0, bus.oReady_AM_WeightBias}, 2'b00);
        check("reset_valids", {bus.oValid_BM_Accum0, bus.oValid_BM_Accum1}, 2'b00);
        check("reset_data", longint'(bus.oData_BM_Accum0), 0);
        bus.iValid_AM_State0     = 1'b0;
        bus.iValid_AM_WeightBias = 1'b0;
        iRST                     = 1'b0;
        tick();

        // Table-driven hand vectors.
        for (int i = 0; i < 4; i++) begin
            runTxn($sformatf("vec%0d", i), vecs[i].st, vecs[i].wb, vecs[i].mode, vecs[i].exp, 1'b0);
        end

        // Join: state valid alone must not be accepted.
        bus.iValid_AM_State0     = 1'b1;
        bus.iValid_AM_WeightBias = 1'b0;
        bus.iData_AM_State0      = vecs[2].st;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("join_wait%0d", i),
                  {bus.oReady_AM_State0, bus.oReady_AM_WeightBias, bus.oValid_BM_Accum0}, 3'b010);
            tick();
        end
        runTxn("join", vecs[2].st, vecs[2].wb, vecs[2].mode, vecs[2].exp, 1'b0);

        // Split back-pressure: Accum1 ready, Accum0 held off for 3 cycles.
        bus.iData_AM_State0      = vecs[0].st;
        bus.iData_AM_WeightBias  = vecs[0].wb;
        bus.iMode                = 1'b1;
        bus.iValid_AM_State0     = 1'b1;
        bus.iValid_AM_WeightBias = 1'b1;
        bus.iReady_BM_Accum0     = 1'b0;
        bus.iReady_BM_Accum1     = 1'b1;
        tick();
        n = 0;
        while (!bus.oValid_BM_Accum0 && n < 200) begin
            tick();
            n++;
        end
        check("split_latency", n, RUNLEN);
        #1;
        check("split_v1_first", bus.oValid_BM_Accum1, 1);
        tick();
        check("split_v1_dropped", bus.oValid_BM_Accum1, 0);
        check("split_v0_held", bus.oValid_BM_Accum0, 1);
        check("split_data_c1", accField(bus.oData_BM_Accum0, 1), -16);
        tick();
        check("split_in_readies", {bus.oReady_AM_State0, bus.oReady_AM_WeightBias}, 2'b00);
        check("split_data_c3", accField(bus.oData_BM_Accum0, 3), -91);
        tick();
        bus.iReady_BM_Accum0 = 1'b1;
        #1;
        check("split_last_wait", {bus.oValid_BM_Accum0, bus.oReady_AM_State0, bus.oReady_AM_WeightBias}, 3'b100);
        tick();
        check("split_idle_valid", bus.oValid_BM_Accum0, 0);
        check("split_idle_readies", {bus.oReady_AM_State0, bus.oReady_AM_WeightBias}, 2'b11);
        check("split_data_stable", accField(bus.oData_BM_Accum0, 0), 56);
        bus.iValid_AM_State0     = 1'b0;
        bus.iValid_AM_WeightBias = 1'b0;
        bus.iReady_BM_Accum0     = 1'b0;
        bus.iReady_BM_Accum1     = 1'b0;
        tick();

        // Reset pulsed in RUN cycle 3 aborts the transaction.
        rst_st = randSt();
        rst_wb = randWB();
        bus.iData_AM_State0      = rst_st;
        bus.iData_AM_WeightBias  = rst_wb;
        bus.iMode                = 1'b1;
        bus.iValid_AM_State0     = 1'b1;
        bus.iValid_AM_WeightBias = 1'b1;
        tick();
        bus.iValid_AM_State0     = 1'b0;
        bus.iValid_AM_WeightBias = 1'b0;
        tick();
        tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        check("abort_valids", {bus.oValid_BM_Accum0, bus.oValid_BM_Accum1}, 2'b00);
        check("abort_data", longint'(bus.oData_BM_Accum0), 0);
        bus.iValid_AM_State0 = 1'b1;
        #1;
        check("abort_idle", bus.oReady_AM_WeightBias, 1);
        bus.iValid_AM_State0 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < RUNLEN + 3; i++) begin
            tick();
            if (bus.oValid_BM_Accum0 || bus.oValid_BM_Accum1) bad = 1'b1;
        end
        check("abort_no_emit", bad, 0);
        runTxn("after_abort", vecs[1].st, vecs[1].wb, vecs[1].mode, vecs[1].exp, 1'b0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 16; i++) begin
            rst_st = randSt();
            rst_wb = randWB();
            rmode  = 1'($urandom_range(0, 1));
            runTxn($sformatf("rand%0d", i), rst_st, rst_wb, rmode, model(rst_st, rst_wb), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
